imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_arbiter_if.sv | 11 +
 rtl/imem_word_packer.sv | 43 ++++
 rtl/imem_arbiter.sv | 132 +++++++++++++
 tb/tb_imem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory arbiter: FSM states,
// memory read/write strobe values and the write range check.
package imem_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Evaluated in 33 bits so a pointer near 2^32 cannot wrap into range.
    function automatic logic in_range(input logic [31:0] addr, input int unsigned mem_bytes);
        return ({1'b0, addr} + 33'd3) < {1'b0, mem_bytes};
    endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Memory-side bus of the arbiter: registered address/data/strobe out,
// read data back from the instruction memory.
interface imem_arbiter_if;
    logic [31:0] IAddr;
    logic [31:0] IDataIn;
    logic        RW;
    logic [31:0] IDataOut;

    modport master (output IAddr, output IDataIn, output RW, input IDataOut);
    modport slave  (input IAddr, input IDataIn, input RW, output IDataOut);
endinterface

// File: rtl/imem_word_packer.sv
// Big-endian byte-to-word packer; word reflects any byte shifted in this
// cycle and zero-fills the low bytes that have not arrived yet.
module imem_word_packer (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  data,
    output logic [2:0]  count,
    output logic [31:0] word
);

    logic [23:0] sr;
    logic [31:0] sr_n;
    logic [2:0]  cnt_n;

    always_comb begin
        sr_n  = shift ? {sr, data} : {8'h00, sr};
        cnt_n = count + {2'b00, shift};
        word  = '0;
        case (cnt_n)
            3'd1:    word = {sr_n[7:0], 24'h0};
            3'd2:    word = {sr_n[15:0], 16'h0};
            3'd3:    word = {sr_n[23:0], 8'h0};
            3'd4:    word = sr_n;
            default: word = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            sr    <= '0;
            count <= '0;
        end else if (clear) begin
            sr    <= '0;
            count <= '0;
        end else if (shift) begin
            sr    <= sr_n[23:0];
            count <= cnt_n;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one instruction memory between CPU fetches and a byte-stream
// program loader; the CPU is held off while a load is in progress.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 300
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        FetchReq,
    input  logic [31:0] FetchAddr,
    output logic [31:0] FetchData,
    output logic        FetchValid,
    output logic        CpuHold,
    input  logic        LoadStart,
    input  logic [31:0] LoadBase,
    input  logic        LoadValid,
    input  logic [7:0]  LoadByte,
    output logic        LoadReady,
    input  logic        LoadDone,
    output logic        LoadErr,
    output logic [15:0] WordCount,
    imem_arbiter_if.master mem
);

    state_t      state, state_n;
    logic [31:0] ptr;
    logic        fin, last;
    logic        shift, pk_clear, word_go;
    logic [2:0]  pk_cnt;
    logic [31:0] pk_word;
    logic        fetch_vld;
    logic        err;
    logic [15:0] wc;

    imem_word_packer u_packer (
        .CLK   (CLK),
        .Reset (Reset),
        .clear (pk_clear),
        .shift (shift),
        .data  (LoadByte),
        .count (pk_cnt),
        .word  (pk_word)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state <= RUN;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        shift    = 1'b0;
        word_go  = 1'b0;
        pk_clear = 1'b0;
        last     = 1'b0;
        case (state)
            RUN: begin
                if (LoadStart) begin
                    state_n  = COLLECT;
                    pk_clear = 1'b1;
                end
            end
            COLLECT: begin
                shift = LoadValid;
                // A byte arriving with LoadDone is folded into the final word.
                if (LoadValid && (pk_cnt == 3'd3 || LoadDone)) begin
                    state_n = WRITE;
                    word_go = 1'b1;
                    last    = LoadDone;
                end else if (LoadDone) begin
                    if (pk_cnt == 3'd0) begin
                        state_n = RUN;
                    end else begin
                        state_n = WRITE;
                        word_go = 1'b1;
                        last    = 1'b1;
                    end
                end
            end
            WRITE: begin
                state_n  = fin ? RUN : COLLECT;
                pk_clear = 1'b1;
            end
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            ptr         <= '0;
            fin         <= 1'b0;
            wc          <= '0;
            err         <= 1'b0;
            fetch_vld   <= 1'b0;
            mem.IAddr   <= '0;
            mem.IDataIn <= '0;
            mem.RW      <= RW_READ;
        end else begin
            fetch_vld <= (state == RUN) && (state_n == RUN) && FetchReq;
            mem.RW    <= RW_READ;
            if (state_n == RUN) mem.IAddr <= FetchAddr;
            if (state == RUN && LoadStart) begin
                ptr <= LoadBase & ~32'h3;
                wc  <= '0;
                err <= 1'b0;
                fin <= 1'b0;
            end
            if (word_go) begin
                mem.IAddr   <= ptr;
                mem.IDataIn <= pk_word;
                fin         <= last;
                if (in_range(ptr, MEM_BYTES)) mem.RW <= RW_WRITE;
                else                          err    <= 1'b1;
            end
            if (state == WRITE) begin
                ptr <= ptr + 32'd4;
                if (wc != 16'hFFFF) wc <= wc + 16'd1;
            end
        end
    end

    // Memory read is combinational on the registered address, so the word
    // is forwarded in the cycle after the request to keep latency at one.
    assign FetchData  = fetch_vld ? mem.IDataOut : '0;
    assign FetchValid = fetch_vld;
    assign CpuHold    = (state != RUN);
    assign LoadReady  = (state == COLLECT);
    assign LoadErr    = err;
    assign WordCount  = wc;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: a queue-based load/fetch model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_imem_arbiter;

    localparam int MB = 300;
    localparam int NW = MB / 4;
    localparam int M_RUN = 0, M_COLLECT = 1, M_WRITE = 2;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        FetchReq, LoadStart, LoadValid, LoadDone;
    logic [31:0] FetchAddr, LoadBase;
    logic [7:0]  LoadByte;
    logic [31:0] FetchData;
    logic        FetchValid, CpuHold, LoadReady, LoadErr;
    logic [15:0] WordCount;

    imem_arbiter_if bus ();

    imem_arbiter #(.MEM_BYTES(MB)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .FetchReq  (FetchReq),
        .FetchAddr (FetchAddr),
        .FetchData (FetchData),
        .FetchValid(FetchValid),
        .CpuHold   (CpuHold),
        .LoadStart (LoadStart),
        .LoadBase  (LoadBase),
        .LoadValid (LoadValid),
        .LoadByte  (LoadByte),
        .LoadReady (LoadReady),
        .LoadDone  (LoadDone),
        .LoadErr   (LoadErr),
        .WordCount (WordCount),
        .mem       (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] preset(input int i);
        return (i == 2) ? 32'h2001_0005 : (32'hC0DE_0000 | i);
    endfunction

    // Instruction memory seen by the DUT.
    logic [31:0] mem [0:NW-1];
    logic        init_done = 1'b0;

    always_comb begin
        bus.IDataOut = 32'h0;
        if (bus.IAddr < MB) bus.IDataOut = mem[bus.IAddr[8:2]];
    end

    always @(posedge CLK) begin
        if (!init_done) begin
            for (int i = 0; i < NW; i++) mem[i] <= preset(i);
            init_done <= 1'b1;
        end else if (Reset && bus.RW == 1'b0 && bus.IAddr < MB) begin
            mem[bus.IAddr[8:2]] <= bus.IDataIn;
        end
    end

    // Reference model: golden memory, byte queue, pointer and counters.
    logic [31:0] gmem [0:NW-1];
    logic [7:0]  q[$];
    int          mode, wc;
    bit          fv, rw, err, fin, wok;
    logic [31:0] faddr, wa, wd, ptr, iaddr_exp;

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return (a < MB) ? gmem[a[8:2]] : 32'h0;
    endfunction

    initial begin : model
        bit          fv_n, rw_n;
        logic [31:0] w;
        for (int i = 0; i < NW; i++) gmem[i] = preset(i);
        forever begin
            @(negedge CLK);
            if (!Reset) begin
                mode = M_RUN; fv = 0; rw = 1; wc = 0; err = 0; ptr = 0;
                iaddr_exp = 0; q.delete();
            end
            chk("hold", CpuHold, mode != M_RUN);
            chk("ready", LoadReady, mode == M_COLLECT);
            chk("fvalid", FetchValid, fv);
            if (fv) chk("fdata", FetchData, exp_word(faddr));
            chk("rw", bus.RW, rw);
            if (mode == M_WRITE) begin
                chk("waddr", bus.IAddr, wa);
                chk("wdata", bus.IDataIn, wd);
            end else if (mode == M_RUN) begin
                chk("iaddr", bus.IAddr, iaddr_exp);
            end
            chk("wcount", WordCount, wc);
            chk("lerr", LoadErr, err);
            if (Reset) begin
                fv_n  = (mode == M_RUN) && FetchReq && !LoadStart;
                faddr = FetchAddr;
                rw_n  = 1;
                case (mode)
                    M_RUN: begin
                        if (LoadStart) begin
                            mode = M_COLLECT; ptr = LoadBase & ~32'h3;
                            wc = 0; err = 0; q.delete();
                        end else begin
                            iaddr_exp = FetchAddr;
                        end
                    end
                    M_COLLECT: begin
                        if (LoadValid) q.push_back(LoadByte);
                        if (q.size() == 4 || (LoadDone && q.size() > 0)) begin
                            w = 0;
                            for (int i = 0; i < 4; i++) w = {w[23:0], (i < q.size()) ? q[i] : 8'h00};
                            wd = w; wa = ptr; fin = LoadDone;
                            wok = (longint'(ptr) + 3) < MB;
                            rw_n = !wok;
                            if (!wok) err = 1;
                            mode = M_WRITE;
                        end else if (LoadDone) begin
                            mode = M_RUN; iaddr_exp = FetchAddr;
                        end
                    end
                    default: begin
                        if (wok) gmem[wa[8:2]] = wd;
                        ptr = ptr + 32'd4;
                        if (wc < 65535) wc++;
                        q.delete();
                        if (fin) begin mode = M_RUN; iaddr_exp = FetchAddr; end
                        else mode = M_COLLECT;
                    end
                endcase
                fv = fv_n; rw = rw_n;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic d);
        int n = 0;
        while (LoadReady !== 1'b1 && n < 8) begin tick(); n++; end
        if (n == 8) chk("ready_timeout", {31'b0, LoadReady}, 32'h1);
        LoadValid = 1; LoadByte = b; LoadDone = d;
        tick();
        LoadValid = 0; LoadDone = 0;
    endtask

    task automatic start_load(input logic [31:0] base);
        LoadStart = 1; LoadBase = base;
        tick();
        LoadStart = 0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] faddrs [4];
        faddrs = '{32'h0, 32'h23, 32'h128, 32'h12C};
        Reset = 0; FetchReq = 0; FetchAddr = 0; LoadStart = 0; LoadBase = 0;
        LoadValid = 0; LoadByte = 0; LoadDone = 0;
        tick(); tick();
        chk("rst_fdata", FetchData, 32'h0);
        chk("rst_fvalid", FetchValid, 0);
        chk("rst_hold", CpuHold, 0);
        chk("rst_ready", LoadReady, 0);
        chk("rst_iaddr", bus.IAddr, 32'h0);
        chk("rst_idata", bus.IDataIn, 32'h0);
        chk("rst_rw", bus.RW, 1);
        chk("rst_wc", WordCount, 0);
        Reset = 1;

        FetchReq = 1; FetchAddr = 32'h8;
        tick();
        chk("fetch_v", FetchValid, 1);
        chk("fetch_d", FetchData, 32'h2001_0005);
        for (int i = 0; i < 4; i++) begin
            FetchAddr = faddrs[i]; FetchReq = (i != 1);
            tick();
        end
        FetchReq = 0;
        tick();
        chk("fetch_idle", FetchValid, 0);

        // Full word; LoadStart inside the load is ignored; LoadDone arrives alone.
        FetchReq = 1; FetchAddr = 32'h4;
        start_load(32'h10);
        FetchReq = 0;
        chk("load_hold", CpuHold, 1);
        chk("load_nofetch", FetchValid, 0);
        send_byte(8'h12, 0);
        LoadStart = 1; LoadBase = 32'h40; tick(); LoadStart = 0;
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        send_byte(8'h78, 0);
        chk("w1_rw", bus.RW, 0);
        chk("w1_addr", bus.IAddr, 32'h10);
        chk("w1_data", bus.IDataIn, 32'h1234_5678);
        tick();
        LoadDone = 1; tick(); LoadDone = 0;
        chk("w1_wc", WordCount, 1);
        chk("w1_hold", CpuHold, 0);
        FetchReq = 1; FetchAddr = 32'h10; tick(); FetchReq = 0;
        chk("w1_fetch", FetchData, 32'h1234_5678);

        start_load(32'h3);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 1);
        chk("part_addr", bus.IAddr, 32'h0);
        chk("part_data", bus.IDataIn, 32'hAABB_0000);
        chk("part_rw", bus.RW, 0);
        tick();

        start_load(32'h20);
        send_byte(8'hC1, 0);
        LoadDone = 1; tick(); LoadDone = 0;
        chk("fill_data", bus.IDataIn, 32'hC100_0000);
        tick();

        // 296+3 = 299 < 300: the last whole word is writable; 300 is not.
        start_load(32'd296);
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 1);
        chk("edge_rw", bus.RW, 0);
        chk("edge_err", LoadErr, 0);
        tick();
        start_load(32'd300);
        send_byte(8'h05, 0); send_byte(8'h06, 0); send_byte(8'h07, 0); send_byte(8'h08, 1);
        chk("oor_rw", bus.RW, 1);
        chk("oor_err", LoadErr, 1);
        tick();
        chk("oor_wc", WordCount, 1);

        // Pointer wraps from the top of the address space back to 0.
        start_load(32'hFFFF_FFFE);
        for (int i = 0; i < 8; i++) send_byte(8'hE0 + 8'(i), i == 7);
        tick();
        chk("wrap_wc", WordCount, 2);
        chk("wrap_err", LoadErr, 1);
        FetchReq = 1; FetchAddr = 32'h0; tick(); FetchReq = 0;
        chk("wrap_fetch", FetchData, 32'hE4E5_E6E7);

        start_load(32'h30);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        Reset = 0;
        #1;
        chk("mrst_hold", CpuHold, 0);
        chk("mrst_rw", bus.RW, 1);
        chk("mrst_iaddr", bus.IAddr, 32'h0);
        chk("mrst_wc", WordCount, 0);
        chk("mrst_err", LoadErr, 0);
        tick();
        Reset = 1;
        FetchReq = 1; FetchAddr = 32'h30; tick(); FetchReq = 0;
        chk("mrst_fv", FetchValid, 1);
        chk("mrst_fd", FetchData, 32'hC0DE_000C);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
